// File: rtl/toggle_counter_ctrl_pkg.sv
// toggle_counter_ctrl_pkg: shared FSM state encoding and default count width
package toggle_counter_ctrl_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/toggle_counter_ctrl_tff_cell.sv
// tff_cell: single T flip-flop with asynchronous active-low clear
module tff_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= 1'b0;
    else q <= q ^ t;
endmodule

// File: rtl/toggle_counter_ctrl.sv
// toggle_counter_ctrl: up/down counter held in a T flip-flop bank, driven only through toggle enables
module toggle_counter_ctrl
  import toggle_counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             dir_up,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done,
  output logic             tc
);
  state_t           state;
  logic             up_q, os_q, go, at_term, stepping;
  logic [WIDTH-1:0] inc_t, dec_t;
  assign go       = start && !stop;
  assign at_term  = up_q ? &cnt : ~|cnt;
  assign stepping = state == RUN && !stop && !(at_term && os_q);
  assign inc_t[0] = 1'b1;
  assign dec_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_t
    assign inc_t[i] = &cnt[i-1:0];
    assign dec_t[i] = ~|cnt[i-1:0];
  end
  // Loading is a toggle too: flipping the bits that differ lands cnt on load_val.
  assign t_vec = state == IDLE ? (go ? cnt ^ load_val : '0)
               : stepping      ? (up_q ? inc_t : dec_t) : '0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_cell u_tff (.clk(clk), .reset_n(reset_n), .t(t_vec[i]), .q(cnt[i]));
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      up_q  <= 1'b1;
      os_q  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      tc <= state == RUN && !stop && at_term && !os_q;
      if (state == IDLE && go) begin
        up_q <= dir_up;
        os_q <= oneshot;
      end
      state <= state == IDLE ? (go ? RUN : IDLE)
             : state == RUN  ? (stop ? IDLE : (at_term && os_q) ? DONE : RUN)
             : IDLE;
    end
  end
endmodule

// File: tb/tb_toggle_counter_ctrl.sv
// tb_toggle_counter_ctrl: directed and random stimulus against an arithmetic reference model
module tb_toggle_counter_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, stop = 1'b0, oneshot = 1'b0, dir_up = 1'b0;
  logic [W-1:0] load_val = '0, cnt, t_vec;
  logic busy, done, tc;
  int total = 0, bad = 0;
  int m_phase;
  logic [W-1:0] m_cnt;
  bit m_up, m_os, m_tc;
  always #5 clk = ~clk;
  toggle_counter_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .oneshot(oneshot),
    .dir_up(dir_up), .load_val(load_val), .cnt(cnt), .t_vec(t_vec),
    .busy(busy), .done(done), .tc(tc)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_phase = 0; m_cnt = '0; m_up = 1'b1; m_os = 1'b0; m_tc = 1'b0;
  endtask
  // Phases: 0 idle, 1 running, 2 finished; next count from plain +/-1 arithmetic.
  task automatic tick();
    logic [W-1:0] ncnt;
    int nphase;
    bit ntc, term, nup, nos;
    @(negedge clk);
    term = m_up ? (m_cnt == {W{1'b1}}) : (m_cnt == '0);
    ncnt = m_cnt; nphase = m_phase; ntc = 1'b0; nup = m_up; nos = m_os;
    if (m_phase == 0) begin
      if (start && !stop) begin
        ncnt = load_val; nphase = 1; nup = dir_up; nos = oneshot;
      end
    end else if (m_phase == 1) begin
      if (stop) nphase = 0;
      else if (term && m_os) nphase = 2;
      else begin
        ncnt = m_up ? m_cnt + 1'b1 : m_cnt - 1'b1;
        ntc = term;
      end
    end else nphase = 0;
    chk("cnt", 32'(cnt), 32'(m_cnt));
    chk("t_vec", 32'(t_vec), 32'(m_cnt ^ ncnt));
    chk("busy", 32'(busy), 32'(m_phase == 1));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("tc", 32'(tc), 32'(m_tc));
    @(posedge clk);
    m_cnt = ncnt; m_phase = nphase; m_tc = ntc; m_up = nup; m_os = nos;
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic begin_run(input bit os, input bit up, input logic [W-1:0] lv);
    start = 1'b1; oneshot = os; dir_up = up; load_val = lv;
    tick();
    start = 1'b0;
  endtask
  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    chk("reset_cnt", 32'(cnt), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_tc", 32'(tc), 32'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    // up oneshot from FA: FA..FF, done, idle holding FF
    begin_run(1'b1, 1'b1, 8'hFA);
    ticks(9);
    chk("req033_hold", 32'(cnt), 32'hFF);
    chk("req033_idle", 32'(busy), 32'h0);
    // down continuous from 02 across the wrap
    begin_run(1'b0, 1'b0, 8'h02);
    dir_up = 1'b1; oneshot = 1'b1; load_val = 8'h77;
    ticks(6);
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    // up from 10, stop at 13
    begin_run(1'b0, 1'b1, 8'h10);
    for (int i = 0; i < 10 && m_cnt != 8'h13; i++) tick();
    chk("req035_reach", 32'(cnt), 32'h13);
    stop = 1'b1; tick(); stop = 1'b0;
    ticks(2);
    chk("req035_freeze", 32'(cnt), 32'h13);
    // park 55 in idle, then start+stop together
    begin_run(1'b0, 1'b1, 8'h55);
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; stop = 1'b1; load_val = 8'hAA; tick();
    start = 1'b0; stop = 1'b0;
    chk("req036_busy", 32'(busy), 32'h0);
    chk("req036_cnt", 32'(cnt), 32'h55);
    tick();
    // start toggling during a run must not disturb it
    begin_run(1'b0, 1'b1, 8'hF0);
    for (int i = 0; i < 24; i++) begin
      start = i[0]; load_val = 8'(i * 37); dir_up = i[1]; oneshot = i[2];
      tick();
    end
    start = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    // asynchronous reset mid-run at 40
    begin_run(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 10 && m_cnt != 8'h40; i++) tick();
    chk("req037_reach", 32'(cnt), 32'h40);
    #2 reset_n = 1'b0;
    #1;
    chk("req037_cnt", 32'(cnt), 32'h0);
    chk("req037_tvec", 32'(t_vec), 32'h0);
    chk("req037_busy", 32'(busy), 32'h0);
    chk("req037_done", 32'(done), 32'h0);
    chk("req037_tc", 32'(tc), 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    ticks(2);
    begin_run(1'b1, 1'b1, 8'hFD);
    ticks(5);
    // down oneshot from terminal 00
    begin_run(1'b1, 1'b0, 8'h00);
    ticks(3);
    chk("req038_cnt", 32'(cnt), 32'h0);
    // random traffic biased toward the terminal values
    for (int i = 0; i < 1500; i++) begin
      int r;
      start = ($urandom_range(0, 5) == 0);
      stop = ($urandom_range(0, 19) == 0);
      dir_up = 1'($urandom);
      oneshot = 1'($urandom);
      r = $urandom_range(0, 2);
      load_val = r == 0 ? 8'($urandom) : r == 1 ? 8'($urandom_range(0, 4)) : 8'(255 - $urandom_range(0, 4));
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/toggle_counter_ctrl.md
TOGGLE_COUNTER_CTRL -- requirements
Module: toggle_counter_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, count width and number of T flip-flop cells.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level; sampled only in IDLE; begins a count run.
REQ-005 stop  input  1  level; aborts a run, returns to IDLE.
REQ-006 oneshot  input  1  sampled with start; 1 = stop at terminal, 0 = wrap continuously.
REQ-007 dir_up  input  1  sampled with start; 1 = increment, 0 = decrement.
REQ-008 load_val  input  WIDTH  start value, sampled with start.
REQ-009 cnt  output  WIDTH  current count, taken directly from the T flip-flop bank.
REQ-010 t_vec  output  WIDTH  toggle enables currently applied to the bank (debug/observe).
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse, high while in DONE.
REQ-013 tc  output  1  registered one-cycle pulse after each continuous-mode wrap.

Function
REQ-014 The count SHALL be held only in a bank of WIDTH T flip-flop cells; the controller changes cnt solely by driving t_vec.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 IDLE: t_vec = 0, cnt holds; on start=1 and stop=0, t_vec = cnt XOR load_val, so cnt = load_val after the edge; dir_up and oneshot are latched; next state RUN.
REQ-017 RUN, dir_up latched 1: t_vec[0]=1, t_vec[i] = AND of cnt[i-1:0] (binary increment by toggles).
REQ-018 RUN, dir_up latched 0: t_vec[0]=1, t_vec[i] = AND of ~cnt[i-1:0] (binary decrement).
REQ-019 Terminal value: all-ones when counting up, zero when counting down.
REQ-020 RUN with cnt at terminal and oneshot latched 1: t_vec = 0, cnt holds, next state DONE.
REQ-021 RUN with cnt at terminal and oneshot latched 0: cnt wraps (all-ones->0 or 0->all-ones) and tc = 1 for the following cycle only; the FSM stays in RUN.
REQ-022 DONE lasts exactly one cycle with done = 1, t_vec = 0; next state IDLE.
REQ-023 stop=1 in RUN: t_vec = 0 that cycle, cnt freezes, next state IDLE, no done pulse, no tc.
REQ-024 start and stop both high in IDLE: stop wins; no load, FSM stays in IDLE.
REQ-025 start in RUN or DONE SHALL be ignored; changes to dir_up, oneshot or load_val during a run SHALL have no effect.
REQ-026 Start latency: cnt = load_val and busy = 1 one cycle after the start edge; first step one cycle after that.
REQ-027 load_val equal to the terminal value in oneshot mode: one RUN cycle, then DONE, then IDLE, and cnt never changes from load_val.

Reset
REQ-028 reset_n low SHALL immediately force: state IDLE, cnt 0, t_vec 0, busy 0, done 0, tc 0, latched dir_up 1, latched oneshot 0.
REQ-029 Reset asserted mid-run SHALL abort without a done or tc pulse; after release the block waits in IDLE for start.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-031 One sub-module, tff_cell (ports clk, reset_n, t, q; asynchronous active-low clear; q toggles when t=1), SHALL be instantiated WIDTH times to form the bank.
REQ-032 tc SHALL be a flop output; busy and done SHALL be decoded from the state register.

Verification (WIDTH=8)
REQ-033 oneshot=1, dir_up=1, load_val=0xFA, start pulse -> cnt FA,FB,...,FF over consecutive cycles, then done high for one cycle, busy low, cnt holds FF.
REQ-034 oneshot=0, dir_up=0, load_val=0x02 -> cnt 02,01,00,FF,FE; tc high exactly in the cycle cnt first reads FF; busy stays high.
REQ-035 RUN counting up from 0x10, stop asserted when cnt=0x13 -> cnt freezes at 13, IDLE next cycle, no done, no tc.
REQ-036 start=1 and stop=1 together in IDLE with cnt=0x55 -> no load, busy stays 0, cnt remains 55; start toggled in RUN -> count sequence undisturbed.
REQ-037 reset_n pulled low between clock edges mid-run at cnt=0x40 -> cnt 00 and all outputs 0 without waiting for a clock edge; normal start after release works.
REQ-038 oneshot=1, dir_up=0, load_val=0x00 -> one busy cycle, done pulse, cnt stays 00; t_vec checked equal to the expected toggle pattern every cycle.
